idli_sqi_arb_m: RTL
===================

# idli_sqi_arb_m

Period-level arbiter and sequencer for the shared SQI memory port. Decides at every 4-cycle period boundary whether the next period is spent on instruction fetch or on a load/store data access. Drives the redirect and read/write controls of the SQI controller and the address-source select for the address mux. Guarantees at least one fetch data period between consecutive data accesses.

## Interface
- ADDR_PERIODS, 2: periods spent in an address phase (command + address + dummy) after any redirect; legal range 1..3.
- i_arb_gck  in  1  core clock.
- i_arb_rst  in  1  reset, synchronous, active-high.
- i_arb_ctr_last_cycle  in  1  high on the last cycle of each 4-cycle period; all state transitions occur only on these edges.
- i_arb_fetch_redirect  in  1  fetch PC changed; a new fetch address must be sent.
- i_arb_mem_req  in  1  load/store pending; held until o_arb_mem_done.
- i_arb_mem_wr  in  1  pending access is a write; sampled at grant only.
- o_arb_sqi_redirect  out  1  SQI controller starts a new transaction (CS cycle + address).
- o_arb_sqi_rd  out  1  1 = read, 0 = write.
- o_arb_addr_sel  out  1  0 = PC, 1 = load/store address.
- o_arb_addr_phase  out  1  current period is an address-phase period.
- o_arb_fetch_data  out  1  current period carries fetch data.
- o_arb_mem_data  out  1  current period carries load/store data.
- o_arb_mem_done  out  1  pulse: last cycle of the data-access data period.
- o_arb_pc_inc  out  1  pulse: last cycle of each fetch data period.

## Operation
- States: F_ADDR, F_DATA, M_ADDR, M_DATA.
- Registers: state, 2-bit period counter pcnt, and wr_q, which holds the latched i_arb_mem_wr.
- Transitions are evaluated only when i_arb_ctr_last_cycle=1. Otherwise the state holds.
- F_ADDR:
  - redirect=1, rd=1, addr_sel=0, addr_phase=1.
  - If i_arb_fetch_redirect=1: stay and set pcnt=0 (restart the address).
  - Else if pcnt==ADDR_PERIODS-1: go to F_DATA with pcnt=0.
  - Else pcnt+1.
  - i_arb_mem_req is ignored in this state.
- F_DATA:
  - rd=1, fetch_data=1, redirect=0.
  - Priority at the boundary:
    1. i_arb_mem_req: go to M_ADDR, set wr_q=i_arb_mem_wr, pcnt=0.
    2. i_arb_fetch_redirect: go to F_ADDR, pcnt=0.
    3. Otherwise stay (sequential stream).
  - Mem and redirect together: go to M_ADDR. The redirect is absorbed, because F_ADDR always follows M_DATA and the PC owner presents the new PC then.
- M_ADDR:
  - redirect=1, rd=!wr_q, addr_sel=1, addr_phase=1.
  - Advances to M_DATA when pcnt==ADDR_PERIODS-1, else pcnt+1.
- M_DATA:
  - rd=!wr_q, mem_data=1, addr_sel=1.
  - Always goes to F_ADDR with pcnt=0.
- During M_*: i_arb_fetch_redirect and deassertion of i_arb_mem_req are ignored. A granted access always completes.
- Fairness is structural: M_ADDR is entered only from F_DATA. Under continuous mem_req the sequence is M_ADDR×ADDR_PERIODS, M_DATA, F_ADDR×ADDR_PERIODS, F_DATA×1, repeat.
- o_arb_pc_inc = (state==F_DATA) & i_arb_ctr_last_cycle. This pulse is combinational.
- o_arb_mem_done = (state==M_DATA) & i_arb_ctr_last_cycle. This pulse is combinational.
- All other outputs are a Moore decode of the registered state and wr_q.
- Any output not listed for a state is 0.

## Timing
- Reset: state=F_ADDR, pcnt=0, wr_q=0.
- Output values during reset and in the cycle after:
  - redirect=1, rd=1, addr_sel=0, addr_phase=1.
  - fetch_data=0, mem_data=0, mem_done=0, pc_inc=0.
- Reset wins over any transition in the same cycle. Reset mid-M_DATA: no mem_done pulse. The requester must re-issue.
- A state change at a last-cycle edge is visible on outputs from the following cycle, which is ctr=0 of the new period.
- Fetch-to-mem latency: a request raised in an F_DATA period is granted at that period's end. mem_done comes (ADDR_PERIODS+1)×4 cycles later.
- Fetch restart after a data access: ADDR_PERIODS×4 cycles of F_ADDR before the first fetch data.
- pcnt never exceeds ADDR_PERIODS-1. There is no wrap-around.
- ctr_last_cycle asserted on consecutive cycles is illegal; behaviour is not required.

## Test plan
- Reset, then ctr_last_cycle every 4th cycle, no requests:
  - 8 cycles with redirect=1, addr_phase=1, addr_sel=0.
  - Then fetch_data=1 steady, pc_inc pulsing every 4 cycles on the last cycle.
- Read access: mem_req=1, mem_wr=0 raised mid-F_DATA:
  - At the boundary: 8 cycles M_ADDR (redirect=1, addr_sel=1, rd=1), then 4 cycles M_DATA.
  - mem_done pulses on cycle 4 of M_DATA.
  - Then F_ADDR with addr_sel=0.
- Continuous mem_req=1: pattern M_ADDR 8, M_DATA 4, F_ADDR 8, F_DATA 4, repeating. Exactly one pc_inc per fetch data period.
- Write: mem_wr=1 at grant, dropped to 0 the next cycle. rd=0 for all 12 cycles of M_ADDR+M_DATA, then rd=1 in F_ADDR.
- Redirect handling:
  - fetch_redirect at an F_DATA boundary: next period F_ADDR.
  - fetch_redirect at the end of the first F_ADDR period: F_ADDR lasts 3 periods total.
  - mem_req and redirect together: goes to M_ADDR.
- Reset asserted on cycle 2 of M_DATA: next cycle shows F_ADDR outputs, mem_data=0, and no mem_done pulse.

Source files
------------

// File: rtl/idli_sqi_arb_m.sv
// Period-level arbiter for the shared SQI port: chooses fetch or load/store
// for each 4-cycle period and drives the SQI controller and address mux selects.
module idli_sqi_arb_m #(
    parameter int ADDR_PERIODS = 2
) (
    input  logic i_arb_gck,
    input  logic i_arb_rst,
    input  logic i_arb_ctr_last_cycle,
    input  logic i_arb_fetch_redirect,
    input  logic i_arb_mem_req,
    input  logic i_arb_mem_wr,
    output logic o_arb_sqi_redirect,
    output logic o_arb_sqi_rd,
    output logic o_arb_addr_sel,
    output logic o_arb_addr_phase,
    output logic o_arb_fetch_data,
    output logic o_arb_mem_data,
    output logic o_arb_mem_done,
    output logic o_arb_pc_inc
);

    typedef enum logic [1:0] {
        F_ADDR = 2'd0,
        F_DATA = 2'd1,
        M_ADDR = 2'd2,
        M_DATA = 2'd3
    } state_e;

    localparam logic [1:0] PCNT_LAST = 2'(ADDR_PERIODS - 1);

    state_e     state_q, state_d;
    logic [1:0] pcnt_q, pcnt_d;
    logic       wr_q, wr_d;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        wr_d    = wr_q;
        if (i_arb_ctr_last_cycle) begin
            case (state_q)
                F_ADDR: begin
                    if (i_arb_fetch_redirect) begin
                        pcnt_d = 2'd0;
                    end else if (pcnt_q == PCNT_LAST) begin
                        state_d = F_DATA;
                        pcnt_d  = 2'd0;
                    end else begin
                        pcnt_d = pcnt_q + 2'd1;
                    end
                end
                F_DATA: begin
                    // A simultaneous redirect is absorbed: F_ADDR always follows M_DATA.
                    if (i_arb_mem_req) begin
                        state_d = M_ADDR;
                        wr_d    = i_arb_mem_wr;
                        pcnt_d  = 2'd0;
                    end else if (i_arb_fetch_redirect) begin
                        state_d = F_ADDR;
                        pcnt_d  = 2'd0;
                    end
                end
                M_ADDR: begin
                    if (pcnt_q == PCNT_LAST) begin
                        state_d = M_DATA;
                        pcnt_d  = 2'd0;
                    end else begin
                        pcnt_d = pcnt_q + 2'd1;
                    end
                end
                M_DATA: begin
                    state_d = F_ADDR;
                    pcnt_d  = 2'd0;
                end
                default: begin
                    state_d = F_ADDR;
                    pcnt_d  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            state_q <= F_ADDR;
            pcnt_q  <= 2'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            wr_q    <= wr_d;
        end
    end

    // Moore decode of the registered state; only the two pulses see ctr_last_cycle.
    always_comb begin
        o_arb_sqi_redirect = 1'b0;
        o_arb_sqi_rd       = 1'b1;
        o_arb_addr_sel     = 1'b0;
        o_arb_addr_phase   = 1'b0;
        o_arb_fetch_data   = 1'b0;
        o_arb_mem_data     = 1'b0;
        o_arb_mem_done     = 1'b0;
        o_arb_pc_inc       = 1'b0;
        case (state_q)
            F_ADDR: begin
                o_arb_sqi_redirect = 1'b1;
                o_arb_addr_phase   = 1'b1;
            end
            F_DATA: begin
                o_arb_fetch_data = 1'b1;
                o_arb_pc_inc     = i_arb_ctr_last_cycle;
            end
            M_ADDR: begin
                o_arb_sqi_redirect = 1'b1;
                o_arb_sqi_rd       = ~wr_q;
                o_arb_addr_sel     = 1'b1;
                o_arb_addr_phase   = 1'b1;
            end
            M_DATA: begin
                o_arb_sqi_rd   = ~wr_q;
                o_arb_addr_sel = 1'b1;
                o_arb_mem_data = 1'b1;
                o_arb_mem_done = i_arb_ctr_last_cycle;
            end
            default: begin
                o_arb_sqi_redirect = 1'b1;
                o_arb_addr_phase   = 1'b1;
            end
        endcase
    end

endmodule
